// File: rtl/cr16_loader_pkg.sv
// Shared types and constants for the CR16 serial boot loader.
package cr16_loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    CHECK   = 3'd5,
    DONE    = 3'd6,
    ERROR   = 3'd7
  } loader_state_t;

  localparam logic [7:0] P_SYNC_BYTE = 8'hA5;

  // True while a frame is being received; timeout and framing errors only matter here.
  function automatic logic in_frame(input loader_state_t s);
    return s inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK};
  endfunction

endpackage

// File: rtl/cr16_uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, start-bit qualification at mid-bit, mid-bit sampling.
module cr16_uart_rx #(
  parameter int P_CLKS_PER_BIT = 434
) (
  input  logic       I_CLK,
  input  logic       I_NRESET,
  input  logic       I_UART_RX,
  output logic [7:0] O_BYTE,
  output logic       O_BYTE_VALID,
  output logic       O_FRAMING_ERROR
);
  localparam int CW = (P_CLKS_PER_BIT > 2) ? $clog2(P_CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF = CW'((P_CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] FULL = CW'(P_CLKS_PER_BIT - 1);

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_BREAK = 3'd4;

  logic [1:0]    sync_q;
  logic [2:0]    st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          vld_q, vld_d, ferr_q, ferr_d;
  logic          rx_s;

  assign rx_s = sync_q[1];

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    vld_d  = 1'b0;
    ferr_d = 1'b0;
    case (st_q)
      RX_IDLE: if (!rx_s) begin
        st_d  = RX_START;
        cnt_d = '0;
      end
      RX_START: if (cnt_q == HALF) begin
        cnt_d = '0;
        bit_d = '0;
        st_d  = rx_s ? RX_IDLE : RX_DATA;
      end else cnt_d = cnt_q + CW'(1);
      RX_DATA: if (cnt_q == FULL) begin
        cnt_d = '0;
        sh_d  = {rx_s, sh_q[7:1]};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) st_d = RX_STOP;
      end else cnt_d = cnt_q + CW'(1);
      RX_STOP: if (cnt_q == FULL) begin
        cnt_d  = '0;
        vld_d  = rx_s;
        ferr_d = !rx_s;
        st_d   = rx_s ? RX_IDLE : RX_BREAK;
      end else cnt_d = cnt_q + CW'(1);
      // A low stop bit must not be mistaken for the next start bit.
      RX_BREAK: if (rx_s) st_d = RX_IDLE;
      default: st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      sync_q <= 2'b11;
      st_q   <= RX_IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      vld_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], I_UART_RX};
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      vld_q  <= vld_d;
      ferr_q <= ferr_d;
    end
  end

  assign O_BYTE          = sh_q;
  assign O_BYTE_VALID    = vld_q;
  assign O_FRAMING_ERROR = ferr_q;

endmodule

// File: rtl/cr16_uart_loader.sv
// CR16 serial boot loader: loads a framed UART image into BRAM port A, holding the core in reset.
// Build option CR16_LOADER_CHECKSUM_EN adds the trailing XOR checksum byte.
module cr16_uart_loader
  import cr16_loader_pkg::*;
#(
  parameter int P_CLKS_PER_BIT   = 434,
  parameter int P_ADDRESS_WIDTH  = 10,
  parameter int P_TIMEOUT_CYCLES = 2**20
) (
  input  logic                       I_CLK,
  input  logic                       I_NRESET,
  input  logic                       I_UART_RX,
  output logic [15:0]                O_MEM_DATA,
  output logic [P_ADDRESS_WIDTH-1:0] O_MEM_ADDRESS,
  output logic                       O_MEM_WRITE_ENABLE,
  output logic                       O_CPU_NRESET,
  output logic                       O_BUSY,
  output logic                       O_DONE,
  output logic                       O_ERROR,
  output logic [15:0]                O_WORD_COUNT
);
  localparam int TW = $clog2(P_TIMEOUT_CYCLES + 1);
  localparam logic [16:0] LEN_MAX = 17'(2**P_ADDRESS_WIDTH);

  logic [7:0] rx_byte;
  logic       rx_vld, rx_ferr;

  cr16_uart_rx #(.P_CLKS_PER_BIT(P_CLKS_PER_BIT)) u_rx (
    .I_CLK           (I_CLK),
    .I_NRESET        (I_NRESET),
    .I_UART_RX       (I_UART_RX),
    .O_BYTE          (rx_byte),
    .O_BYTE_VALID    (rx_vld),
    .O_FRAMING_ERROR (rx_ferr)
  );

  loader_state_t st_q, st_d;
  logic [15:0]   len_q, len_d, cnt_q, cnt_d, data_q, data_d;
  logic [7:0]    hi_q, hi_d;
  logic          we_q, we_d, busy_q, done_q, err_q;
  logic [TW-1:0] tmo_q;
  logic          sync_ok, tmo_hit;

  assign sync_ok = rx_vld && (rx_byte == P_SYNC_BYTE) && (st_q inside {IDLE, DONE, ERROR});
  assign tmo_hit = in_frame(st_q) && !rx_vld && (tmo_q == TW'(P_TIMEOUT_CYCLES - 1));

`ifdef CR16_LOADER_CHECKSUM_EN
  logic [7:0] chk_q;
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) chk_q <= '0;
    else if (sync_ok) chk_q <= '0;
    else if (rx_vld && (st_q inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO})) chk_q <= chk_q ^ rx_byte;
  end
`endif

  always_comb begin
    st_d   = st_q;
    len_d  = len_q;
    hi_d   = hi_q;
    data_d = data_q;
    we_d   = 1'b0;
    // Address and word count advance on the cycle after the strobe.
    cnt_d  = we_q ? cnt_q + 16'd1 : cnt_q;
    case (st_q)
      IDLE, DONE, ERROR: if (sync_ok) begin
        st_d  = LEN_HI;
        cnt_d = '0;
      end
      LEN_HI: if (rx_vld) begin
        len_d[15:8] = rx_byte;
        st_d        = LEN_LO;
      end
      LEN_LO: if (rx_vld) begin
        len_d[7:0] = rx_byte;
        if ({len_q[15:8], rx_byte} == 16'd0)             st_d = CHECK;
        else if ({1'b0, len_q[15:8], rx_byte} > LEN_MAX) st_d = ERROR;
        else                                             st_d = DATA_HI;
      end
      DATA_HI: if (rx_vld) begin
        hi_d = rx_byte;
        st_d = DATA_LO;
      end
      DATA_LO: if (rx_vld) begin
        we_d   = 1'b1;
        data_d = {hi_q, rx_byte};
        st_d   = (cnt_q == len_q - 16'd1) ? CHECK : DATA_HI;
      end
      CHECK: begin
`ifdef CR16_LOADER_CHECKSUM_EN
        if (rx_vld) st_d = (rx_byte == chk_q) ? DONE : ERROR;
`else
        st_d = DONE;
`endif
      end
      default: st_d = IDLE;
    endcase
    if (in_frame(st_q) && (rx_ferr || tmo_hit)) st_d = ERROR;
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      st_q   <= IDLE;
      len_q  <= '0;
      hi_q   <= '0;
      data_q <= '0;
      cnt_q  <= '0;
      we_q   <= 1'b0;
      tmo_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      len_q  <= len_d;
      hi_q   <= hi_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
      we_q   <= we_d;
      tmo_q  <= (!in_frame(st_q) || rx_vld) ? '0 : (tmo_hit ? tmo_q : tmo_q + TW'(1));
      busy_q <= in_frame(st_d);
      // Status follows the state by one cycle but drops on the accepting edge of a reload.
      done_q <= (st_q == DONE) && !sync_ok;
      err_q  <= (st_q == ERROR) && !sync_ok;
    end
  end

  assign O_MEM_DATA         = data_q;
  assign O_MEM_ADDRESS      = cnt_q[P_ADDRESS_WIDTH-1:0];
  assign O_MEM_WRITE_ENABLE = we_q;
  assign O_WORD_COUNT       = cnt_q;
  assign O_CPU_NRESET       = done_q;
  assign O_DONE             = done_q;
  assign O_ERROR            = err_q;
  assign O_BUSY             = busy_q;

endmodule

// File: tb/tb_cr16_uart_loader.sv
// Self-checking bench for cr16_uart_loader: directed frames plus randomized frames vs. a frame model.
module tb_cr16_uart_loader;
  localparam int CPB = 16;
  localparam int AW  = 10;
  localparam int TMO = 3000;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          rx = 1'b1;
  logic [15:0]   mem_data;
  logic [AW-1:0] mem_addr;
  logic          we, cpu_nrst, busy, done, err;
  logic [15:0]   wc;

  int total = 0;
  int bad = 0;
  int stretch = 0;
  logic prev_we = 1'b0;

  logic [7:0]  tx_q[$];
  logic [31:0] got_w[$];
  logic [31:0] exp_w[$];
  logic        exp_done, exp_err;
  int          exp_wc;

  cr16_uart_loader #(
    .P_CLKS_PER_BIT  (CPB),
    .P_ADDRESS_WIDTH (AW),
    .P_TIMEOUT_CYCLES(TMO)
  ) dut (
    .I_CLK             (clk),
    .I_NRESET          (nrst),
    .I_UART_RX         (rx),
    .O_MEM_DATA        (mem_data),
    .O_MEM_ADDRESS     (mem_addr),
    .O_MEM_WRITE_ENABLE(we),
    .O_CPU_NRESET      (cpu_nrst),
    .O_BUSY            (busy),
    .O_DONE            (done),
    .O_ERROR           (err),
    .O_WORD_COUNT      (wc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we) got_w.push_back({6'b0, mem_addr, mem_data});
    if (we && prev_we) stretch <= stretch + 1;
    prev_we <= we;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = !bad_stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  // Expected outcome of tx_q derived from the frame format; a missing tail means a timeout.
  task automatic model();
    int len, nw, ci;
    logic [7:0] x;
    logic [9:0] a;
    exp_w.delete();
    len = {tx_q[1], tx_q[2]};
    exp_done = 1'b0;
    exp_err  = 1'b1;
    exp_wc   = 0;
    if (len > (1 << AW)) return;
    nw = (tx_q.size() - 3) / 2;
    if (nw > len) nw = len;
    x = tx_q[1] ^ tx_q[2];
    for (int i = 0; i < nw; i++) begin
      a = 10'(i);
      exp_w.push_back({6'b0, a, tx_q[3 + 2 * i], tx_q[4 + 2 * i]});
      x = x ^ tx_q[3 + 2 * i] ^ tx_q[4 + 2 * i];
    end
    exp_wc = nw;
    if (nw < len) return;
    ci = 3 + 2 * len;
`ifdef CR16_LOADER_CHECKSUM_EN
    if (tx_q.size() > ci && tx_q[ci] == x) begin
      exp_done = 1'b1;
      exp_err  = 1'b0;
    end
`else
    if (ci >= 0) begin
      exp_done = 1'b1;
      exp_err  = 1'b0;
    end
`endif
  endtask

  task automatic wait_end();
    int n = 0;
    @(negedge clk);
    while (!(done || err) && n < TMO + 500) begin
      @(negedge clk);
      n++;
    end
    check("wait_end", 32'(n < TMO + 500), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_frame(input string tag);
    got_w.delete();
    model();
    foreach (tx_q[i]) send_byte(tx_q[i], 1'b0);
    wait_end();
    check({tag, ".done"}, 32'(done), 32'(exp_done));
    check({tag, ".error"}, 32'(err), 32'(exp_err));
    check({tag, ".cpu_nreset"}, 32'(cpu_nrst), 32'(exp_done));
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".word_count"}, 32'(wc), 32'(exp_wc));
    check({tag, ".nwrites"}, 32'(got_w.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++)
      check({tag, ".write"}, (i < got_w.size()) ? got_w[i] : 32'hDEAD_DEAD, exp_w[i]);
  endtask

  initial begin
    logic [7:0] x;
    int len;
    repeat (4) @(negedge clk);
    check("rst.done", 32'(done), 0);
    check("rst.error", 32'(err), 0);
    check("rst.cpu_nreset", 32'(cpu_nrst), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.we", 32'(we), 0);
    check("rst.word_count", 32'(wc), 0);
    check("rst.addr", 32'(mem_addr), 0);
    nrst = 1'b1;
    repeat (4) @(negedge clk);

    tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef CR16_LOADER_CHECKSUM_EN
    tx_q.push_back(8'h42);
`endif
    run_frame("t1");

    tx_q = '{8'hA5, 8'h00, 8'h00};
`ifdef CR16_LOADER_CHECKSUM_EN
    tx_q.push_back(8'h00);
`endif
    run_frame("t2");

`ifdef CR16_LOADER_CHECKSUM_EN
    tx_q = '{8'hA5, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'h01};
    run_frame("t3");
`endif

    tx_q = '{8'hA5, 8'h04, 8'h01};
    run_frame("t4");

    tx_q = '{8'hA5, 8'h00, 8'h03, 8'h11};
    run_frame("t5a");
    tx_q = '{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF};
`ifdef CR16_LOADER_CHECKSUM_EN
    tx_q.push_back(8'h00 ^ 8'h01 ^ 8'hBE ^ 8'hEF);
`endif
    run_frame("t5b");

    // Reset mid-frame after three words.
    got_w.delete();
    tx_q = '{8'hA5, 8'h00, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    foreach (tx_q[i]) send_byte(tx_q[i], 1'b0);
    repeat (3) @(negedge clk);
    check("t6.busy_mid", 32'(busy), 1);
    check("t6.wc_mid", 32'(wc), 3);
    check("t6.nwrites", 32'(got_w.size()), 3);
    check("t6.write2", (got_w.size() > 2) ? got_w[2] : 32'hDEAD_DEAD, {6'b0, 10'd2, 16'h0506});
    nrst = 1'b0;
    #1;
    check("t6.rst_busy", 32'(busy), 0);
    check("t6.rst_wc", 32'(wc), 0);
    check("t6.rst_cpu", 32'(cpu_nrst), 0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    send_byte(8'h5A, 1'b0);
    repeat (3) @(negedge clk);
    check("t6.stray_busy", 32'(busy), 0);
    send_byte(8'hA5, 1'b1);
    repeat (3) @(negedge clk);
    check("t6.badstop_busy", 32'(busy), 0);
    check("t6.badstop_err", 32'(err), 0);
    tx_q = '{8'hA5, 8'h00, 8'h01, 8'h77, 8'h88};
`ifdef CR16_LOADER_CHECKSUM_EN
    tx_q.push_back(8'h01 ^ 8'h77 ^ 8'h88);
`endif
    run_frame("t6c");

    for (int it = 0; it < 6; it++) begin
      x = 8'($urandom_range(0, 255));
      if (x == 8'hA5) x = 8'h5A;
      send_byte(x, 1'b0);
      len = $urandom_range(1, 6);
      tx_q = '{8'hA5, 8'h00, 8'(len)};
      x = 8'(len);
      for (int i = 0; i < 2 * len; i++) begin
        tx_q.push_back(8'($urandom_range(0, 255)));
        x = x ^ tx_q[tx_q.size() - 1];
      end
`ifdef CR16_LOADER_CHECKSUM_EN
      if ($urandom_range(0, 2) == 0) x = x ^ 8'($urandom_range(1, 255));
      tx_q.push_back(x);
`endif
      run_frame("rnd");
    end

    check("strobe_one_cycle", 32'(stretch), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
